// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the streaming instruction prefetcher.
package instr_fetch_pkg;

    localparam int MAX_BRAM_LATENCY = 4;

    // Sequential address step that wraps at the memory depth, so ADDRS need not be a power of two.
    function automatic int wrap_inc(input int addr, input int addrs);
        return (addr == addrs - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Small synchronous FIFO holding fetched {addr, op} entries; flush empties it in one edge.
module instruction_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A flush discards whatever arrives alongside it; a coincident pop is subsumed by the flush.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_prefetcher.sv
// Streaming instruction fetch: one BRAM read per cycle, latency-tracked into a FIFO drained by the CPU.
module instruction_prefetcher
    import instr_fetch_pkg::*;
#(
    parameter int ADDRS        = 256,
    parameter int OP_SIZE      = 8,
    parameter int BRAM_LATENCY = 2,
    parameter int DEPTH        = 4,
    localparam int ADDR_SIZE   = $clog2(ADDRS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 jump_in,
    input  logic [ADDR_SIZE-1:0] jump_addr_in,
    output logic [OP_SIZE-1:0]   instruction_out,
    output logic [ADDR_SIZE-1:0] addr_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    input  logic [OP_SIZE-1:0]   bram_dout,
    output logic [ADDR_SIZE-1:0] bram_addr,
    output logic                 bram_we,
    output logic                 bram_regce,
    output logic [OP_SIZE-1:0]   bram_din
);

    localparam int ENTRY_W = ADDR_SIZE + OP_SIZE;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int INF_W   = $clog2(MAX_BRAM_LATENCY + 1);
    localparam int OCC_W   = $clog2(DEPTH + MAX_BRAM_LATENCY + 1);

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [OP_SIZE-1:0]   op;
    } fetch_entry_t;

    logic [ADDR_SIZE-1:0]    fetch_addr;
    logic [BRAM_LATENCY-1:0] trk_valid;
    logic [ADDR_SIZE-1:0]    trk_addr [BRAM_LATENCY];
    logic [INF_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic [OCC_W-1:0]        occupancy;
    logic                    issue;
    logic                    push;
    logic                    pop;
    fetch_entry_t            push_entry;
    fetch_entry_t            head_entry;

    assign bram_addr  = fetch_addr;
    assign bram_we    = 1'b0;
    assign bram_regce = 1'b1;
    assign bram_din   = '0;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            inflight = inflight + INF_W'(trk_valid[i]);
        end
    end

    // Credit uses registered counts only, so a pop this cycle frees a slot one cycle later.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
    assign issue     = !jump_in && (occupancy < OCC_W'(DEPTH));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_addr <= '0;
        end else if (jump_in) begin
            fetch_addr <= jump_addr_in;
        end else if (issue) begin
            fetch_addr <= ADDR_SIZE'(wrap_inc(int'(fetch_addr), ADDRS));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || jump_in) begin
            trk_valid <= '0;
        end else begin
            trk_valid[0] <= issue;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                trk_valid[i] <= trk_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        trk_addr[0] <= fetch_addr;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            trk_addr[i] <= trk_addr[i-1];
        end
    end

    assign push       = trk_valid[BRAM_LATENCY-1];
    assign push_entry = '{addr: trk_addr[BRAM_LATENCY-1], op: bram_dout};
    assign pop        = valid_out && ready_in;

    instruction_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .pop       (pop),
        .flush     (jump_in),
        .push_data (push_entry),
        .head      (head_entry),
        .count     (fifo_count)
    );

    // Head is masked while empty so reset and flushed states read as zero.
    assign valid_out       = (fifo_count != '0);
    assign instruction_out = valid_out ? head_entry.op : '0;
    assign addr_out        = valid_out ? head_entry.addr : '0;

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Bench for instruction_prefetcher: two configurations, directed timing steps plus random traffic vs a stream model.
module tb_instruction_prefetcher;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults (ADDRS=256, latency 2, depth 4)
    logic       rst_a, jump_a, ready_a, valid_a, we_a, regce_a;
    logic [7:0] jaddr_a, instr_a, addr_a, dout_a, baddr_a, din_a;
    logic [7:0] pipe_a [2];

    // Instance B: ADDRS=200, latency 3, depth 8
    logic       rst_b, jump_b, ready_b, valid_b, we_b, regce_b;
    logic [7:0] jaddr_b, instr_b, addr_b, dout_b, baddr_b, din_b;
    logic [7:0] pipe_b [3];

    instruction_prefetcher u_a (
        .clk_in(clk_in), .rst_in(rst_a), .jump_in(jump_a), .jump_addr_in(jaddr_a),
        .instruction_out(instr_a), .addr_out(addr_a), .valid_out(valid_a), .ready_in(ready_a),
        .bram_dout(dout_a), .bram_addr(baddr_a), .bram_we(we_a), .bram_regce(regce_a), .bram_din(din_a)
    );

    instruction_prefetcher #(.ADDRS(200), .OP_SIZE(8), .BRAM_LATENCY(3), .DEPTH(8)) u_b (
        .clk_in(clk_in), .rst_in(rst_b), .jump_in(jump_b), .jump_addr_in(jaddr_b),
        .instruction_out(instr_b), .addr_out(addr_b), .valid_out(valid_b), .ready_in(ready_b),
        .bram_dout(dout_b), .bram_addr(baddr_b), .bram_we(we_b), .bram_regce(regce_b), .bram_din(din_b)
    );

    // BRAM models: word at address a is a+8'h10, returned BRAM_LATENCY edges after capture
    always @(posedge clk_in) begin
        pipe_a[0] <= baddr_a;
        pipe_a[1] <= pipe_a[0];
        pipe_b[0] <= baddr_b;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign dout_a = pipe_a[1] + 8'h10;
    assign dout_b = pipe_b[2] + 8'h10;

    // Stream model: next address the CPU must receive from each instance
    int exp_a = 0, exp_b = 0;
    int xfer_a = 0, xfer_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: check transfers mid-cycle, apply reset/jump to the model, land 1ns after the edge.
    task automatic tick();
        @(negedge clk_in);
        if (valid_a === 1'b1 && ready_a) begin
            check("a_xfer_addr", 32'(addr_a), 32'(exp_a));
            check("a_xfer_instr", 32'(instr_a), 32'((exp_a + 16) % 256));
            exp_a = (exp_a + 1) % 256;
            xfer_a++;
        end
        if (rst_a) exp_a = 0;
        else if (jump_a) exp_a = int'(jaddr_a);
        if (valid_b === 1'b1 && ready_b) begin
            check("b_xfer_addr", 32'(addr_b), 32'(exp_b));
            check("b_xfer_instr", 32'(instr_b), 32'((exp_b + 16) % 256));
            exp_b = (exp_b + 1) % 200;
            xfer_b++;
        end
        if (rst_b) exp_b = 0;
        else if (jump_b) exp_b = int'(jaddr_b);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int  x0;
        logic kill;
        rst_a = 1; jump_a = 0; jaddr_a = '0; ready_a = 0;
        rst_b = 1; jump_b = 0; jaddr_b = '0; ready_b = 0;
        @(posedge clk_in);
        #1;
        repeat (2) tick();

        check("a_rst_valid", 32'(valid_a), 0);
        check("a_rst_instr", 32'(instr_a), 0);
        check("a_rst_addr", 32'(addr_a), 0);
        check("a_bram_we", 32'(we_a), 0);
        check("a_bram_regce", 32'(regce_a), 1);
        check("a_bram_din", 32'(din_a), 0);

        // First word visible three cycles after release, then one per cycle
        rst_a = 0; ready_a = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("a_first_valid", 32'(valid_a), 32'(i == 3));
        end
        check("a_first_addr", 32'(addr_a), 0);
        check("a_first_instr", 32'(instr_a), 32'h10);
        repeat (20) begin
            tick();
            check("a_stream_valid", 32'(valid_a), 1);
        end
        check("a_stream_count", 32'(xfer_a), 20);

        // CPU stalled: exactly DEPTH reads issue, then the address freezes
        ready_a = 0; rst_a = 1;
        tick();
        rst_a = 0;
        repeat (10) tick();
        check("a_hold_bram_addr", 32'(baddr_a), 4);
        check("a_hold_valid", 32'(valid_a), 1);
        tick();
        check("a_hold_bram_addr2", 32'(baddr_a), 4);
        ready_a = 1;
        x0 = xfer_a;
        for (int i = 0; i < 12; i++) begin
            check("a_drain_valid", 32'(valid_a), 1);
            tick();
        end
        check("a_drain_count", 32'(xfer_a - x0), 12);

        // Jump while the FIFO is loaded and reads are in flight
        ready_a = 0; rst_a = 1;
        tick();
        rst_a = 0;
        repeat (5) tick();
        jump_a = 1; jaddr_a = 8'h40;
        tick();
        jump_a = 0;
        for (int i = 1; i < 4; i++) begin
            check("a_jump_gap", 32'(valid_a), 0);
            tick();
        end
        check("a_jump_valid", 32'(valid_a), 1);
        check("a_jump_addr", 32'(addr_a), 32'h40);
        ready_a = 1;
        repeat (8) tick();

        // Back-to-back jumps: only the second target survives
        jump_a = 1; jaddr_a = 8'h20;
        tick();
        jaddr_a = 8'h80;
        tick();
        jump_a = 0;
        for (int i = 1; i < 4; i++) begin
            check("a_jj_gap", 32'(valid_a), 0);
            tick();
        end
        check("a_jj_valid", 32'(valid_a), 1);
        check("a_jj_addr", 32'(addr_a), 32'h80);
        repeat (8) tick();

        // Random traffic on A
        x0 = xfer_a;
        for (int i = 0; i < 400; i++) begin
            ready_a = ($urandom_range(0, 3) != 0);
            jump_a  = ($urandom_range(0, 15) == 0);
            jaddr_a = 8'($urandom_range(0, 255));
            rst_a   = ($urandom_range(0, 63) == 0);
            kill = rst_a || jump_a;
            tick();
            if (kill) check("a_rand_kill", 32'(valid_a), 0);
        end
        rst_a = 0; jump_a = 0; ready_a = 1;
        repeat (10) tick();
        check("a_rand_progress", 32'(xfer_a - x0 > 50), 1);

        // B: reset state and latency-3 first fetch
        check("b_rst_valid", 32'(valid_b), 0);
        check("b_rst_addr", 32'(addr_b), 0);
        rst_b = 0; ready_b = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("b_first_valid", 32'(valid_b), 32'(i == 4));
        end
        check("b_first_addr", 32'(addr_b), 0);

        // Wrap from 199 to 0 on non-power-of-two depth
        jump_b = 1; jaddr_b = 8'd196;
        tick();
        jump_b = 0;
        for (int i = 1; i < 5; i++) begin
            check("b_jump_gap", 32'(valid_b), 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            check("b_wrap_valid", 32'(valid_b), 1);
            check("b_wrap_addr", 32'(addr_b), 32'((196 + i) % 200));
            tick();
        end

        // One-cycle reset mid-stream
        repeat (5) tick();
        rst_b = 1;
        tick();
        rst_b = 0;
        check("b_midrst_valid", 32'(valid_b), 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("b_midrst_gap", 32'(valid_b), 0);
        end
        tick();
        check("b_restart_valid", 32'(valid_b), 1);
        check("b_restart_addr", 32'(addr_b), 0);
        repeat (10) tick();

        // Random traffic on B
        x0 = xfer_b;
        for (int i = 0; i < 300; i++) begin
            ready_b = ($urandom_range(0, 3) != 0);
            jump_b  = ($urandom_range(0, 15) == 0);
            jaddr_b = 8'($urandom_range(0, 199));
            rst_b   = ($urandom_range(0, 63) == 0);
            kill = rst_b || jump_b;
            tick();
            if (kill) check("b_rand_kill", 32'(valid_b), 0);
        end
        rst_b = 0; jump_b = 0; ready_b = 1;
        repeat (12) tick();
        check("b_rand_progress", 32'(xfer_b - x0 > 40), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
